vga_timing_gen: RTL and testbench

- Parametrised, single-clock VGA raster timing generator. Next generation of the display timing logic.
- Produces hsync, vsync, blank and data-enable signals plus active-area pixel coordinates.
- Issues one line-fetch request per displayed line, with a valid/ready handshake, to the display memory fetch engine.
- Configuration is double-buffered and applied only at a frame boundary, so a mode change never tears a frame.

---
 rtl/vga_timing_gen_if.sv | 14 +
 rtl/vga_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Line-fetch request channel between the raster timing generator and the
// display memory fetch engine (valid/ready handshake).
interface vga_timing_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int PITCH_W = 13
);
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic [PITCH_W-1:0] req_words;

  modport master (output req_valid, output req_addr, output req_words, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_words, output req_ready);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered sync/blank/de and
// pixel coordinates, one line-fetch request per displayed line, and a
// double-buffered configuration that only changes at a frame boundary.
module vga_timing_gen #(
  parameter int CNT_W      = 12,
  parameter int ADDR_W     = 32,
  parameter int PITCH_W    = 13,
  parameter int WORD_SHIFT = 4
) (
  input  logic               vga_clk,
  input  logic               vga_reset_n,
  input  logic               en,
  input  logic [CNT_W-1:0]   cfg_h_start,
  input  logic [CNT_W-1:0]   cfg_h_width,
  input  logic [CNT_W-1:0]   cfg_h_sync,
  input  logic [CNT_W-1:0]   cfg_h_total,
  input  logic [CNT_W-1:0]   cfg_v_start,
  input  logic [CNT_W-1:0]   cfg_v_width,
  input  logic [CNT_W-1:0]   cfg_v_sync,
  input  logic [CNT_W-1:0]   cfg_v_total,
  input  logic [1:0]         cfg_polarity,
  input  logic [ADDR_W-1:0]  cfg_disp_addr,
  input  logic [PITCH_W-1:0] cfg_pitch,
  input  logic               cfg_load,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_hblank,
  output logic               vga_vblank,
  output logic               vga_de,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               frame_start,
  vga_timing_gen_if.master   req,
  output logic               overrun
);

  typedef struct packed {
    logic [CNT_W-1:0]   h_start;
    logic [CNT_W-1:0]   h_width;
    logic [CNT_W-1:0]   h_sync;
    logic [CNT_W-1:0]   h_total;
    logic [CNT_W-1:0]   v_start;
    logic [CNT_W-1:0]   v_width;
    logic [CNT_W-1:0]   v_sync;
    logic [CNT_W-1:0]   v_total;
    logic [1:0]         polarity;
    logic [ADDR_W-1:0]  disp_addr;
    logic [PITCH_W-1:0] pitch;
  } cfg_t;

  // 640x480@60 timing out of reset
  localparam cfg_t CFG_RST = '{
    h_start: CNT_W'(48), h_width: CNT_W'(640), h_sync: CNT_W'(96), h_total: CNT_W'(799),
    v_start: CNT_W'(33), v_width: CNT_W'(480), v_sync: CNT_W'(2),  v_total: CNT_W'(524),
    polarity: 2'b00, disp_addr: '0, pitch: PITCH_W'(1280)
  };

  cfg_t             cfg_in, pend, act;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W:0]   h_x, v_x, nv, h_end, v_end;
  logic             h_wrap, v_wrap, frame_wrap, h_on, v_on, hs_on, vs_on, nv_on, issue;
  logic [ADDR_W-1:0]  next_addr;
  logic [PITCH_W-1:0] next_words;

  // Timing decode of the current counter position; one extra bit avoids wrap aliasing
  always_comb begin
    cfg_in     = '{cfg_h_start, cfg_h_width, cfg_h_sync, cfg_h_total,
                   cfg_v_start, cfg_v_width, cfg_v_sync, cfg_v_total,
                   cfg_polarity, cfg_disp_addr, cfg_pitch};
    h_x        = {1'b0, h_cnt};
    v_x        = {1'b0, v_cnt};
    h_wrap     = h_cnt >= act.h_total;
    v_wrap     = v_cnt >= act.v_total;
    frame_wrap = en & h_wrap & v_wrap;
    h_end      = {1'b0, act.h_start} + {1'b0, act.h_width};
    v_end      = {1'b0, act.v_start} + {1'b0, act.v_width};
    h_on       = (h_x >= {1'b0, act.h_start}) && (h_x < h_end);
    v_on       = (v_x >= {1'b0, act.v_start}) && (v_x < v_end);
    // h > total - sync, rearranged so nothing goes negative
    hs_on      = (h_x + {1'b0, act.h_sync}) > {1'b0, act.h_total};
    vs_on      = (v_x + {1'b0, act.v_sync}) > {1'b0, act.v_total};
    nv         = v_wrap ? '0 : v_x + (CNT_W+1)'(1);
    nv_on      = (nv >= {1'b0, act.v_start}) && (nv < v_end);
    issue      = en & h_wrap & nv_on;
    next_addr  = (nv == {1'b0, act.v_start}) ? act.disp_addr
                                             : req.req_addr + ADDR_W'(act.pitch);
    next_words = (act.pitch >> WORD_SHIFT) + PITCH_W'(|act.pitch[WORD_SHIFT-1:0]);
  end

  // Pending/active configuration; a load coinciding with the frame wrap wins
  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      pend <= CFG_RST;
      act  <= CFG_RST;
    end else begin
      if (cfg_load) pend <= cfg_in;
      if (!en || frame_wrap) act <= cfg_load ? cfg_in : pend;
    end
  end

  // Raster counters, held at (0,0) while disabled
  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Registered video outputs, one cycle behind the counters
  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      vga_hsync   <= 1'b0;
      vga_vsync   <= 1'b0;
      vga_hblank  <= 1'b1;
      vga_vblank  <= 1'b1;
      vga_de      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      vga_hsync   <= act.polarity[1];
      vga_vsync   <= act.polarity[0];
      vga_hblank  <= 1'b1;
      vga_vblank  <= 1'b1;
      vga_de      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= hs_on ^ act.polarity[1];
      vga_vsync   <= vs_on ^ act.polarity[0];
      vga_hblank  <= ~h_on;
      vga_vblank  <= ~v_on;
      vga_de      <= h_on & v_on;
      pix_x       <= h_cnt - act.h_start;
      pix_y       <= v_cnt - act.v_start;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Line-fetch request: a due request overwrites an unaccepted one and flags overrun
  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      req.req_valid <= 1'b0;
      req.req_addr  <= '0;
      req.req_words <= '0;
      overrun       <= 1'b0;
    end else begin
      if (!en) begin
        req.req_valid <= 1'b0;
      end else if (issue) begin
        req.req_valid <= 1'b1;
        req.req_addr  <= next_addr;
        req.req_words <= next_words;
      end else if (req.req_valid && req.req_ready) begin
        req.req_valid <= 1'b0;
      end
      if (issue && req.req_valid && !req.req_ready) overrun <= 1'b1;
      else if (cfg_load)                             overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: cycle reference model plus directed sequences.
module tb_vga_timing_gen;
  localparam int CNT_W = 12, ADDR_W = 32, PITCH_W = 13, WORD_SHIFT = 4;

  logic vga_clk, vga_reset_n, en, cfg_load, req_ready;
  logic [CNT_W-1:0] cfg_h_start, cfg_h_width, cfg_h_sync, cfg_h_total;
  logic [CNT_W-1:0] cfg_v_start, cfg_v_width, cfg_v_sync, cfg_v_total;
  logic [1:0] cfg_polarity;
  logic [ADDR_W-1:0] cfg_disp_addr;
  logic [PITCH_W-1:0] cfg_pitch;
  logic vga_hsync, vga_vsync, vga_hblank, vga_vblank, vga_de, frame_start, overrun;
  logic [CNT_W-1:0] pix_x, pix_y;

  vga_timing_gen_if #(.ADDR_W(ADDR_W), .PITCH_W(PITCH_W)) req_if ();
  assign req_if.req_ready = req_ready;

  vga_timing_gen #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .PITCH_W(PITCH_W), .WORD_SHIFT(WORD_SHIFT)) dut (
    .vga_clk(vga_clk), .vga_reset_n(vga_reset_n), .en(en),
    .cfg_h_start(cfg_h_start), .cfg_h_width(cfg_h_width), .cfg_h_sync(cfg_h_sync), .cfg_h_total(cfg_h_total),
    .cfg_v_start(cfg_v_start), .cfg_v_width(cfg_v_width), .cfg_v_sync(cfg_v_sync), .cfg_v_total(cfg_v_total),
    .cfg_polarity(cfg_polarity), .cfg_disp_addr(cfg_disp_addr), .cfg_pitch(cfg_pitch), .cfg_load(cfg_load),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_hblank(vga_hblank), .vga_vblank(vga_vblank),
    .vga_de(vga_de), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .req(req_if), .overrun(overrun)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks, errors, nprint;
  bit chk_on;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (nprint < 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      nprint++;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int hs, hw, hsy, ht, vs, vw, vsy, vt; logic [1:0] pol; logic [31:0] addr; int pitch; } mcfg_t;

  function automatic mcfg_t cfg_default();
    mcfg_t c;
    c.hs = 48; c.hw = 640; c.hsy = 96; c.ht = 799;
    c.vs = 33; c.vw = 480; c.vsy = 2;  c.vt = 524;
    c.pol = 2'b00; c.addr = 32'h0; c.pitch = 1280;
    return c;
  endfunction

  function automatic mcfg_t cfg_ports();
    mcfg_t c;
    c.hs = int'(cfg_h_start); c.hw = int'(cfg_h_width); c.hsy = int'(cfg_h_sync); c.ht = int'(cfg_h_total);
    c.vs = int'(cfg_v_start); c.vw = int'(cfg_v_width); c.vsy = int'(cfg_v_sync); c.vt = int'(cfg_v_total);
    c.pol = cfg_polarity; c.addr = cfg_disp_addr; c.pitch = int'(cfg_pitch);
    return c;
  endfunction

  int mh, mv, e_px, e_py, e_words;
  mcfg_t m_act, m_pend;
  logic e_hs, e_vs, e_hb, e_vb, e_de, e_fs, e_valid, e_ovr;
  logic [31:0] e_addr;

  always @(posedge vga_clk or negedge vga_reset_n) begin : model
    mcfg_t np;
    int nv;
    bit hon, von;
    if (!vga_reset_n) begin
      mh <= 0; mv <= 0; m_act <= cfg_default(); m_pend <= cfg_default();
      e_hs <= 1'b0; e_vs <= 1'b0; e_hb <= 1'b1; e_vb <= 1'b1; e_de <= 1'b0; e_fs <= 1'b0;
      e_px <= 0; e_py <= 0; e_valid <= 1'b0; e_ovr <= 1'b0; e_addr <= 32'h0; e_words <= 0;
    end else begin
      np = cfg_load ? cfg_ports() : m_pend;
      m_pend <= np;
      if (cfg_load) e_ovr <= 1'b0;
      if (!en) begin
        mh <= 0; mv <= 0; m_act <= np;
        e_hs <= m_act.pol[1]; e_vs <= m_act.pol[0]; e_hb <= 1'b1; e_vb <= 1'b1;
        e_de <= 1'b0; e_fs <= 1'b0; e_px <= 0; e_py <= 0; e_valid <= 1'b0;
      end else begin
        hon = (mh >= m_act.hs) && (mh < m_act.hs + m_act.hw);
        von = (mv >= m_act.vs) && (mv < m_act.vs + m_act.vw);
        e_hb <= !hon; e_vb <= !von; e_de <= hon && von;
        e_hs <= (mh > m_act.ht - m_act.hsy) ^ m_act.pol[1];
        e_vs <= (mv > m_act.vt - m_act.vsy) ^ m_act.pol[0];
        e_px <= (mh - m_act.hs) & 'hFFF;
        e_py <= (mv - m_act.vs) & 'hFFF;
        e_fs <= (mh == 0) && (mv == 0);
        if (mh >= m_act.ht) begin
          nv = (mv >= m_act.vt) ? 0 : mv + 1;
          mh <= 0; mv <= nv;
          if (mv >= m_act.vt) m_act <= np;
          if (nv >= m_act.vs && nv < m_act.vs + m_act.vw) begin
            e_valid <= 1'b1;
            e_addr  <= (nv == m_act.vs) ? m_act.addr : e_addr + 32'(m_act.pitch);
            e_words <= (m_act.pitch + 15) / 16;
            if (e_valid && !req_ready) e_ovr <= 1'b1;
          end else if (e_valid && req_ready) e_valid <= 1'b0;
        end else begin
          mh <= mh + 1;
          if (e_valid && req_ready) e_valid <= 1'b0;
        end
      end
    end
  end

  always @(negedge vga_clk) begin
    if (chk_on) begin
      cmp("hsync", vga_hsync, e_hs);
      cmp("vsync", vga_vsync, e_vs);
      cmp("hblank", vga_hblank, e_hb);
      cmp("vblank", vga_vblank, e_vb);
      cmp("de", vga_de, e_de);
      cmp("frame_start", frame_start, e_fs);
      if (e_de) begin
        cmp("pix_x", pix_x, e_px);
        cmp("pix_y", pix_y, e_py);
      end
      cmp("req_valid", req_if.req_valid, e_valid);
      if (e_valid) begin
        cmp("req_addr", req_if.req_addr, e_addr);
        cmp("req_words", req_if.req_words, e_words);
      end
      cmp("overrun", overrun, e_ovr);
    end
  end

  // accepted requests
  logic [31:0] acc_q[$];
  int acc_w[$];
  always @(posedge vga_clk) begin
    if (vga_reset_n && req_if.req_valid && req_ready) begin
      acc_q.push_back(req_if.req_addr);
      acc_w.push_back(int'(req_if.req_words));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge vga_clk);
    #1;
  endtask

  task automatic set_cfg(input int hs, hw, hsy, ht, vs, vw, vsy, vt,
                         input logic [1:0] pol, input logic [31:0] addr, input int pitch);
    cfg_h_start = CNT_W'(hs); cfg_h_width = CNT_W'(hw); cfg_h_sync = CNT_W'(hsy); cfg_h_total = CNT_W'(ht);
    cfg_v_start = CNT_W'(vs); cfg_v_width = CNT_W'(vw); cfg_v_sync = CNT_W'(vsy); cfg_v_total = CNT_W'(vt);
    cfg_polarity = pol; cfg_disp_addr = addr; cfg_pitch = PITCH_W'(pitch);
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  task automatic load_small(input logic [31:0] addr, input int pitch);
    en = 1'b0;
    set_cfg(2, 6, 2, 11, 1, 4, 1, 7, 2'b00, addr, pitch);
    pulse_load();
    tick(2);
  endtask

  task automatic wait_fs(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge vga_clk);
      if (frame_start) begin ok = 1; break; end
    end
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge vga_clk);
      if (req_if.req_valid) begin ok = 1; break; end
    end
    #1;
  endtask

  // counts de cycles up to the next frame_start; optionally pulses cfg_load after cycle load_at
  task automatic frame_scan(input int budget, input int load_at, output int de, output int ncyc, output bit ok);
    de = 0; ncyc = 0; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge vga_clk);
      ncyc++;
      if (frame_start) begin ok = 1; break; end
      if (vga_de) de++;
      #1;
      cfg_load = (i == load_at);
    end
    #1;
    cfg_load = 1'b0;
  endtask

  typedef struct { logic [31:0] base; int pitch; int exp_words; logic [31:0] exp_addr2; } vec_t;
  vec_t vecs[5];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int hs_cnt, hact_cnt, de_cnt, ncyc, n0, vcnt;
    logic [31:0] a0;

    vecs[0] = '{32'h0000_1000,   80,   5, 32'h0000_1050};
    vecs[1] = '{32'h0000_0000, 1280,  80, 32'h0000_0500};
    vecs[2] = '{32'h0000_0020,   17,   2, 32'h0000_0031};
    vecs[3] = '{32'hFFFF_FFF0,    1,   1, 32'hFFFF_FFF1};
    vecs[4] = '{32'h0000_0100, 8191, 512, 32'h0000_20FF};

    checks = 0; errors = 0; nprint = 0; chk_on = 0;
    vga_reset_n = 1'b0; en = 1'b0; cfg_load = 1'b0; req_ready = 1'b1;
    set_cfg(48, 640, 96, 799, 33, 480, 2, 524, 2'b00, 32'h0, 1280);
    chk_on = 1;
    tick(3);
    cmp("rst_hsync", vga_hsync, 1'b0);
    cmp("rst_vsync", vga_vsync, 1'b0);
    cmp("rst_hblank", vga_hblank, 1'b1);
    cmp("rst_vblank", vga_vblank, 1'b1);
    cmp("rst_de", vga_de, 1'b0);
    cmp("rst_fs", frame_start, 1'b0);
    cmp("rst_req_valid", req_if.req_valid, 1'b0);
    cmp("rst_overrun", overrun, 1'b0);

    // default timing, first two lines
    vga_reset_n = 1'b1; en = 1'b1;
    hs_cnt = 0; hact_cnt = 0; de_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge vga_clk);
      if (vga_hsync) hs_cnt++;
      if (!vga_hblank) hact_cnt++;
      if (vga_de) de_cnt++;
    end
    #1;
    cmp("dflt_hsync_cycles", hs_cnt, 192);
    cmp("dflt_hactive_cycles", hact_cnt, 1280);
    cmp("dflt_de_top_lines", de_cnt, 0);

    // small mode: period, de area, requests per frame
    load_small(32'h1000, 80);
    en = 1'b1;
    wait_fs(50, ok);
    cmp("small_fs_seen", ok, 1'b1);
    n0 = acc_q.size();
    frame_scan(300, -1, de_cnt, ncyc, ok);
    cmp("small_fs_next", ok, 1'b1);
    cmp("small_frame_period", ncyc, 96);
    cmp("small_de_cycles", de_cnt, 24);
    cmp("small_req_per_frame", acc_q.size() - n0, 4);

    // width change mid-frame takes effect only at the next frame
    cfg_h_width = CNT_W'(3);
    frame_scan(300, 30, de_cnt, ncyc, ok);
    cmp("midload_fs", ok, 1'b1);
    cmp("midload_cur_frame_de", de_cnt, 24);
    frame_scan(300, -1, de_cnt, ncyc, ok);
    cmp("midload_next_frame_de", de_cnt, 12);

    // table: first two request addresses and word counts
    foreach (vecs[k]) begin
      load_small(vecs[k].base, vecs[k].pitch);
      acc_q.delete(); acc_w.delete();
      req_ready = 1'b1; en = 1'b1;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
        tick(1);
        if (acc_q.size() >= 2) begin ok = 1; break; end
      end
      cmp("vec_two_reqs", ok, 1'b1);
      if (ok) begin
        cmp("vec_addr0", acc_q[0], vecs[k].base);
        cmp("vec_addr1", acc_q[1], vecs[k].exp_addr2);
        cmp("vec_words", acc_w[0], vecs[k].exp_words);
      end
    end

    // ready held low across two request points
    load_small(32'h1000, 80);
    en = 1'b1;
    wait_fs(50, ok);
    req_ready = 1'b0;
    wait_valid(30, ok);
    cmp("ovr_valid_seen", ok, 1'b1);
    a0 = req_if.req_addr;
    cmp("ovr_first_addr", a0, 32'h1000);
    cmp("ovr_before", overrun, 1'b0);
    tick(12);
    cmp("ovr_valid_held", req_if.req_valid, 1'b1);
    cmp("ovr_addr_adv", req_if.req_addr, a0 + 32'd80);
    cmp("ovr_set", overrun, 1'b1);
    tick(30);
    cmp("ovr_sticky", overrun, 1'b1);
    wait_fs(200, ok);
    pulse_load();
    cmp("ovr_clr_by_load", overrun, 1'b0);
    req_ready = 1'b1;

    // inverted polarity while disabled
    en = 1'b0;
    cfg_polarity = 2'b11;
    pulse_load();
    tick(3);
    cmp("pol_hsync", vga_hsync, 1'b1);
    cmp("pol_vsync", vga_vsync, 1'b1);
    cmp("pol_hblank", vga_hblank, 1'b1);
    cmp("pol_vblank", vga_vblank, 1'b1);
    n0 = acc_q.size(); vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vga_clk);
      if (req_if.req_valid) vcnt++;
    end
    #1;
    cmp("pol_no_valid", vcnt, 0);
    cmp("pol_no_accept", acc_q.size() - n0, 0);
    cfg_polarity = 2'b00;
    pulse_load();

    // randomized configs, handshake and enable
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge vga_clk);
      #1;
      req_ready = 1'($urandom_range(0, 1));
      cfg_load = ($urandom_range(0, 59) == 0);
      if (cfg_load) begin : rnd_cfg
        int ht, vt;
        ht = int'($urandom_range(6, 20));
        vt = int'($urandom_range(3, 10));
        set_cfg(int'($urandom_range(0, ht)), int'($urandom_range(1, ht)), int'($urandom_range(1, 3)), ht,
                int'($urandom_range(0, vt)), int'($urandom_range(1, vt)), int'($urandom_range(1, 2)), vt,
                2'($urandom_range(0, 3)), $urandom, int'($urandom_range(1, 8191)));
      end
      if ($urandom_range(0, 199) == 0) en = ~en;
    end
    cfg_load = 1'b0;

    // reset pulse mid-line with a request pending
    load_small(32'h2000, 64);
    en = 1'b1; req_ready = 1'b0;
    wait_fs(50, ok);
    tick(29);
    cmp("prerst_valid", req_if.req_valid, 1'b1);
    #2 vga_reset_n = 1'b0;
    #1;
    cmp("midrst_valid", req_if.req_valid, 1'b0);
    cmp("midrst_de", vga_de, 1'b0);
    cmp("midrst_hblank", vga_hblank, 1'b1);
    cmp("midrst_vblank", vga_vblank, 1'b1);
    cmp("midrst_overrun", overrun, 1'b0);
    @(negedge vga_clk);
    #1 vga_reset_n = 1'b1;
    wait_fs(5, ok);
    cmp("postrst_fs", ok, 1'b1);
    hs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge vga_clk);
      if (vga_hsync) hs_cnt++;
      #1;
      req_ready = 1'($urandom_range(0, 1));
    end
    cmp("postrst_hsync_cycles", hs_cnt, 96);

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
